// File: rtl/sha3_absorb_ctrl.sv
// sha3_absorb_ctrl
//
// Absorb sequencer for the SHA-3 accelerator. It takes 64-bit message words
// from the word buffer (valid/ready) and writes them lane by lane into the
// Keccak state-XOR port. It applies SHA-3 padding (0x06 domain byte, 0x80
// final bit), starts the permutation after every full rate block, and pulses
// msg_done once the permutation of the last padded block has finished.
//
// Ports
//   clk         clock
//   RST         synchronous active-high reset
//   in_data     message word, little-endian bytes (byte k = bits 8k+7:8k)
//   in_valid    in_data valid
//   in_last     word is the last of the message
//   in_nbytes   valid bytes in the last word (0..8, values above 8 act as 8)
//   in_ready    controller accepts a word this cycle
//   lane_data   value to XOR into state lane lane_idx
//   lane_idx    lane index 0..RATE_WORDS-1
//   lane_we     lane write strobe
//   perm_start  one-cycle pulse: start the permutation
//   perm_done   one-cycle pulse from the core: permutation finished
//   busy        a message is in progress
//   msg_done    one-cycle pulse: final permutation finished
module sha3_absorb_ctrl #(
  parameter int RATE_WORDS = 17,
  parameter int W          = 64
) (
  input  logic         clk,
  input  logic         RST,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [3:0]   in_nbytes,
  output logic         in_ready,
  output logic [W-1:0] lane_data,
  output logic [4:0]   lane_idx,
  output logic         lane_we,
  output logic         perm_start,
  input  logic         perm_done,
  output logic         busy,
  output logic         msg_done
);

  localparam logic [4:0] R_LAST = 5'(RATE_WORDS - 1);
  localparam logic [4:0] R_FULL = 5'(RATE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PAD,
    S_PERM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         final_q, final_d;
  // A last word of 8 bytes in the final lane leaves no room for padding:
  // a whole extra block of padding follows that block's permutation.
  logic         extra_q, extra_d;
  // The 0x06 domain byte is still owed to the first padding lane.
  logic         pad06_q, pad06_d;
  logic         lane_we_q, lane_we_d;
  logic [4:0]   lane_idx_q, lane_idx_d;
  logic [W-1:0] lane_data_q, lane_data_d;

  logic         ready_int;
  logic         accept;
  logic [3:0]   n_eff;

  // Mask bytes n..7 of the last word and insert the padding bytes that fit.
  function automatic logic [W-1:0] pad_last(input logic [W-1:0] d,
                                            input logic [3:0]   n,
                                            input logic         last_lane);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(n)) r[8*k +: 8] = d[8*k +: 8];
    end
    if (n < 4'd8) begin
      r[{n[2:0], 3'b000} +: 8] = r[{n[2:0], 3'b000} +: 8] | 8'h06;
      if (last_lane) r[W-1 -: 8] = r[W-1 -: 8] | 8'h80;
    end
    return r;
  endfunction

  // Content of a lane written purely by padding.
  function automatic logic [W-1:0] pad_lane(input logic first06,
                                            input logic last_lane);
    logic [W-1:0] r;
    r = '0;
    if (first06)   r[7:0]      = 8'h06;
    if (last_lane) r[W-1 -: 8] = 8'h80;
    return r;
  endfunction

  assign ready_int = ((state_q == S_IDLE) || (state_q == S_ABSORB)) && (cnt_q < R_FULL);
  assign accept    = in_valid && ready_int;
  assign n_eff     = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    final_d     = final_q;
    extra_d     = extra_q;
    pad06_d     = pad06_q;
    lane_we_d   = 1'b0;
    lane_idx_d  = lane_idx_q;
    lane_data_d = lane_data_q;

    case (state_q)
      S_IDLE, S_ABSORB: begin
        if (accept) begin
          lane_we_d  = 1'b1;
          lane_idx_d = cnt_q;
          cnt_d      = cnt_q + 5'd1;
          if (in_last) begin
            lane_data_d = pad_last(in_data, n_eff, cnt_q == R_LAST);
            final_d     = 1'b1;
            pad06_d     = (n_eff == 4'd8);
            extra_d     = (n_eff == 4'd8) && (cnt_q == R_LAST);
            // In the final lane the block is already full: let the counter
            // reach RATE_WORDS and fall into PERM like any full block.
            state_d     = (cnt_q == R_LAST) ? S_ABSORB : S_PAD;
          end else begin
            lane_data_d = in_data;
            state_d     = S_ABSORB;
          end
        end else if ((state_q == S_ABSORB) && (cnt_q == R_FULL)) begin
          // The write of the final lane is on the port this cycle.
          state_d = S_PERM;
        end
      end
      S_PAD: begin
        if (cnt_q == R_FULL) begin
          state_d = S_PERM;
        end else begin
          lane_we_d   = 1'b1;
          lane_idx_d  = cnt_q;
          lane_data_d = pad_lane(pad06_q, cnt_q == R_LAST);
          pad06_d     = 1'b0;
          cnt_d       = cnt_q + 5'd1;
        end
      end
      S_PERM: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (perm_done) begin
          cnt_d = '0;
          if (extra_q) begin
            extra_d = 1'b0;
            state_d = S_PAD;
          end else if (final_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ABSORB;
          end
        end
      end
      S_DONE: begin
        final_d = 1'b0;
        pad06_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      final_q     <= 1'b0;
      extra_q     <= 1'b0;
      pad06_q     <= 1'b0;
      lane_we_q   <= 1'b0;
      lane_idx_q  <= '0;
      lane_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      final_q     <= final_d;
      extra_q     <= extra_d;
      pad06_q     <= pad06_d;
      lane_we_q   <= lane_we_d;
      lane_idx_q  <= lane_idx_d;
      lane_data_q <= lane_data_d;
    end
  end

  // State-decoded outputs are held low for as long as reset is asserted.
  assign in_ready   = !RST && ready_int;
  assign perm_start = !RST && (state_q == S_PERM);
  assign msg_done   = !RST && (state_q == S_DONE);
  assign busy       = !RST && ((state_q == S_ABSORB) || (state_q == S_PAD) ||
                               (state_q == S_PERM)   || (state_q == S_WAIT));
  assign lane_we    = lane_we_q;
  assign lane_idx   = lane_idx_q;
  assign lane_data  = lane_data_q;

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Testbench for sha3_absorb_ctrl. Expected lane writes come from a byte-level
// SHA-3 pad10*1 model (append 0x06, zero-fill to the rate, OR 0x80 into the
// final byte) pushed into a scoreboard queue and popped as lanes are written.
module tb_sha3_absorb_ctrl;

  localparam int R = 17;

  logic        clk;
  logic        RST;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [3:0]  in_nbytes;
  logic        in_ready;
  logic [63:0] lane_data;
  logic [4:0]  lane_idx;
  logic        lane_we;
  logic        perm_start;
  logic        perm_done;
  logic        busy;
  logic        msg_done;

  sha3_absorb_ctrl #(.RATE_WORDS(R), .W(64)) dut (
    .clk        (clk),
    .RST        (RST),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_nbytes  (in_nbytes),
    .in_ready   (in_ready),
    .lane_data  (lane_data),
    .lane_idx   (lane_idx),
    .lane_we    (lane_we),
    .perm_start (perm_start),
    .perm_done  (perm_done),
    .busy       (busy),
    .msg_done   (msg_done)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] data;
  } lane_t;

  lane_t      sb[$];
  logic [7:0] msg_q[$];
  logic [7:0] pad_q[$];
  lane_t      mon_e;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int perm_cnt = 0;
  int msg_cnt = 0;
  int cyc = 0;
  int pd_cyc = -10;
  int lanes_in_block = 0;
  int exp_blocks = 0;
  int perm_delay = 3;
  bit outstanding = 0;
  bit resp_busy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Permutation core stand-in: answers each perm_start after perm_delay cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (perm_start && !RST) begin
        resp_busy = 1;
        repeat (perm_delay) @(posedge clk);
        #1 perm_done = 1'b1;
        @(posedge clk);
        #1 perm_done = 1'b0;
        resp_busy = 0;
      end
    end
  end

  // Output monitor: scoreboard pops, permutation and completion checks.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (RST) begin
        outstanding    = 0;
        lanes_in_block = 0;
      end else begin
        if (outstanding) chk("ready_low_during_perm", 64'(in_ready), 64'(0));
        if (lane_we) begin
          if (sb.size() == 0) begin
            chk("lane_we_unexpected", 64'(lane_we), 64'(0));
          end else begin
            mon_e = sb.pop_front();
            chk("lane_idx", 64'(lane_idx), 64'(mon_e.idx));
            chk("lane_data", lane_data, mon_e.data);
          end
          lanes_in_block++;
        end
        if (perm_start) begin
          chk("perm_overlap", 64'(outstanding), 64'(0));
          chk("perm_block_lanes", 64'(lanes_in_block), 64'(R));
          lanes_in_block = 0;
          outstanding    = 1;
          perm_cnt++;
        end
        if (perm_done) begin
          outstanding = 0;
          pd_cyc      = cyc;
        end
        if (msg_done) begin
          chk("msg_done_latency", 64'(cyc), 64'(pd_cyc + 1));
          chk("busy_at_msg_done", 64'(busy), 64'(0));
          msg_cnt++;
        end
      end
    end
  end

  task automatic fill_rand(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  // SHA-3 padding of msg_q into whole rate blocks, pushed as lane writes.
  task automatic build_expected();
    logic [63:0] w;
    lane_t       e;
    int          nb;
    pad_q = msg_q;
    pad_q.push_back(8'h06);
    while ((pad_q.size() % (8 * R)) != 0) pad_q.push_back(8'h00);
    pad_q[pad_q.size() - 1] = pad_q[pad_q.size() - 1] | 8'h80;
    nb = pad_q.size() / 8;
    exp_blocks = nb / R;
    for (int j = 0; j < nb; j++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = pad_q[8*j + b];
      e.idx  = 5'(j % R);
      e.data = w;
      sb.push_back(e);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] n);
    int c;
    c = 0;
    in_data   = d;
    in_last   = l;
    in_nbytes = n;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("handshake_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Drives msg_q as words (unused bytes of the last word set to 0xFF) and
  // waits for completion. big_n sends in_nbytes=15 for a full last word.
  task automatic run_msg(input string name, input bit big_n);
    int          len, nw, avail, pc0, mc0, c;
    logic [63:0] w;
    logic        last;
    logic [3:0]  nb;
    build_expected();
    pc0 = perm_cnt;
    mc0 = msg_cnt;
    len = msg_q.size();
    nw  = (len == 0) ? 1 : (len + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      avail = len - 8 * i;
      if (avail > 8) avail = 8;
      if (avail < 0) avail = 0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = (b < avail) ? msg_q[8*i + b] : 8'hFF;
      last = (i == nw - 1);
      if (last) nb = (big_n && avail == 8) ? 4'd15 : 4'(avail);
      else      nb = 4'(i % 16);
      send_word(w, last, nb);
      if (i == 0) chk({name, "_busy_rise"}, 64'(busy), 64'(1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    c = 0;
    while (msg_cnt == mc0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    chk({name, "_msg_done_count"}, 64'(msg_cnt - mc0), 64'(1));
    chk({name, "_perm_count"}, 64'(perm_cnt - pc0), 64'(exp_blocks));
    chk({name, "_all_lanes_written"}, 64'(sb.size()), 64'(0));
    chk({name, "_busy_after"}, 64'(busy), 64'(0));
    sb.delete();
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({pfx, "_lane_we"}, 64'(lane_we), 64'(0));
    chk({pfx, "_perm_start"}, 64'(perm_start), 64'(0));
    chk({pfx, "_busy"}, 64'(busy), 64'(0));
    chk({pfx, "_msg_done"}, 64'(msg_done), 64'(0));
    chk({pfx, "_lane_idx"}, 64'(lane_idx), 64'(0));
    chk({pfx, "_lane_data"}, lane_data, 64'(0));
  endtask

  initial begin
    int c, mc0;
    RST       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nbytes = 4'd0;
    in_data   = 64'd0;
    perm_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    RST = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));

    // Empty message
    msg_q.delete();
    run_msg("t1_empty", 0);

    // 3-byte message: lane0 = 0x0000_0000_06AA_BBCC
    msg_q.delete();
    msg_q.push_back(8'hCC);
    msg_q.push_back(8'hBB);
    msg_q.push_back(8'hAA);
    run_msg("t2_3byte", 0);

    // Exactly one block of data: extra padding block
    fill_rand(136);
    run_msg("t3_136", 0);
    fill_rand(136);
    run_msg("t3_136_nbytes15", 1);

    // n=7 in lane 16 gives 0x86 in the top byte
    fill_rand(135);
    run_msg("t4_n7_lane16", 0);

    // n=8 in lane 4, and n=8 in lane 15
    fill_rand(40);
    run_msg("t4_n8_lane4", 0);
    fill_rand(128);
    run_msg("n8_lane15", 0);

    // 40-word stream, in_valid held, slow permutation
    perm_delay = 10;
    fill_rand(320);
    run_msg("t5_backpressure", 0);

    // Reset during WAIT, then a stray perm_done
    msg_q.delete();
    build_expected();
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    c = 0;
    while (!outstanding && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("t6_perm_started", 64'(outstanding), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("t6_reset");
    chk("t6_lanes_before_reset", 64'(sb.size()), 64'(0));
    sb.delete();
    mc0 = msg_cnt;
    RST = 1'b0;
    c = 0;
    while (resp_busy && c < 50) begin
      @(posedge clk);
      c++;
    end
    chk("t6_stray_done_sent", 64'(resp_busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_msg_done", 64'(msg_cnt), 64'(mc0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_in_ready", 64'(in_ready), 64'(1));

    perm_delay = 3;
    msg_q.delete();
    run_msg("t6_empty_again", 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
